write_sm: RTL and testbench



---
 rtl/write_sm.sv | 187 ++++++++++++++++++
 tb/tb_write_sm.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_sm.sv
// write_sm: producer end of the level handshake between complex multiplier stages.
// Captures a block of WORDS words on run and hands them out one at a time,
// raising handshake per word, waiting for the consumer's ack pulse, then
// holding handshake low for GAP_CYCLES before the next word. done pulses
// once the last word has been handed over.
// Optional feature: define WRITE_SM_TIMEOUT_EN to abort a word that is not
// acknowledged within TIMEOUT cycles (sticky timeout_err, no done pulse).
module write_sm #(
  parameter int WIDTH      = 16,
  parameter int WORDS      = 2,
  parameter int GAP_CYCLES = 1
`ifdef WRITE_SM_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 255
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [WORDS*WIDTH-1:0] data_in,
  input  logic                   ack,
  output logic                   handshake,
  output logic [WIDTH-1:0]       data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               handshake_q, handshake_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   buf_q [WORDS];
  logic [WIDTH-1:0]   buf_d [WORDS];
  logic [IDX_W-1:0]   idx_next;
  logic [WIDTH-1:0]   next_word;

`ifdef WRITE_SM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Select the buffered word that follows the one currently presented.
  always_comb begin
    idx_next  = idx_q + 1'b1;
    next_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_next == IDX_W'(k)) begin
        next_word = buf_q[k];
      end
    end
  end

  // Next-state and next-output logic of the transfer state machine.
  always_comb begin
    state_d     = state_q;
    handshake_d = handshake_q;
    data_out_d  = data_out_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    buf_d       = buf_q;
`ifdef WRITE_SM_TIMEOUT_EN
    wait_d        = wait_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (run) begin
          for (int k = 0; k < WORDS; k++) begin
            buf_d[k] = data_in[k*WIDTH +: WIDTH];
          end
          idx_d       = '0;
          data_out_d  = data_in[WIDTH-1:0];
          handshake_d = 1'b1;
          state_d     = S_PRESENT;
`ifdef WRITE_SM_TIMEOUT_EN
          wait_d        = '0;
          timeout_err_d = 1'b0;
`endif
        end
      end

      S_PRESENT: begin
        if (ack) begin
          handshake_d = 1'b0;
          gap_d       = GAP_LOAD;
          state_d     = S_GAP;
        end
`ifdef WRITE_SM_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          handshake_d   = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end

      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d       = idx_next;
          data_out_d  = next_word;
          handshake_d = 1'b1;
          state_d     = S_PRESENT;
`ifdef WRITE_SM_TIMEOUT_EN
          wait_d = '0;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        handshake_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      handshake_q <= 1'b0;
      data_out_q  <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      for (int k = 0; k < WORDS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      handshake_q <= handshake_d;
      data_out_q  <= data_out_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      buf_q       <= buf_d;
    end
  end

`ifdef WRITE_SM_TIMEOUT_EN
  // Ack wait counter and sticky abort flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign handshake = handshake_q;
  assign data_out  = data_out_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_write_sm.sv
// tb_write_sm: directed checks of write_sm on three instances
// (2 words/gap 1, 3 words/gap 3, 1 word/gap 1).
module tb_write_sm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        run_a, ack_a, hs_a, busy_a, done_a, terr_a;
  logic [31:0] din_a;
  logic [15:0] dout_a;

  logic        run_b, ack_b, hs_b, busy_b, done_b, terr_b;
  logic [47:0] din_b;
  logic [15:0] dout_b;

  logic        run_c, ack_c, hs_c, busy_c, done_c, terr_c;
  logic [15:0] din_c;
  logic [15:0] dout_c;

  int total = 0;
  int bad   = 0;

  write_sm #(
    .WIDTH(16), .WORDS(2), .GAP_CYCLES(1)
`ifdef WRITE_SM_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run_a), .data_in(din_a), .ack(ack_a),
    .handshake(hs_a), .data_out(dout_a), .busy(busy_a), .done(done_a),
    .timeout_err(terr_a)
  );

  write_sm #(.WIDTH(16), .WORDS(3), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run_b), .data_in(din_b), .ack(ack_b),
    .handshake(hs_b), .data_out(dout_b), .busy(busy_b), .done(done_b),
    .timeout_err(terr_b)
  );

  write_sm #(.WIDTH(16), .WORDS(1), .GAP_CYCLES(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .run(run_c), .data_in(din_c), .ack(ack_c),
    .handshake(hs_c), .data_out(dout_c), .busy(busy_c), .done(done_c),
    .timeout_err(terr_c)
  );

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run_a = 0; ack_a = 0; din_a = '0;
    run_b = 0; ack_b = 0; din_b = '0;
    run_c = 0; ack_c = 0; din_c = '0;
    tick();
    tick();
    total++; if (hs_a !== 1'b0)    begin bad++; $display("[TB] FAIL reset_hs_a: got %b want 0", hs_a); end
    total++; if (dout_a !== 16'h0) begin bad++; $display("[TB] FAIL reset_dout_a: got %h want 0000", dout_a); end
    total++; if (busy_a !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy_a: got %b want 0", busy_a); end
    total++; if (done_a !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done_a: got %b want 0", done_a); end
    total++; if (terr_a !== 1'b0)  begin bad++; $display("[TB] FAIL reset_terr_a: got %b want 0", terr_a); end
    total++; if (hs_b !== 1'b0 || busy_b !== 1'b0 || dout_b !== 16'h0) begin bad++; $display("[TB] FAIL reset_b: got hs=%b busy=%b dout=%h want 0 0 0000", hs_b, busy_b, dout_b); end
    total++; if (hs_c !== 1'b0 || busy_c !== 1'b0 || dout_c !== 16'h0) begin bad++; $display("[TB] FAIL reset_c: got hs=%b busy=%b dout=%h want 0 0 0000", hs_c, busy_c, dout_c); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0]  exp_hs, exp_done, exp_busy;
    logic [15:0] exp_d [8];
    exp_hs   = 8'b0001_1011;
    exp_done = 8'b0100_0000;
    exp_busy = 8'b0111_1111;
    exp_d    = '{16'h1234, 16'h1234, 16'h1234, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    din_a = {16'hBEEF, 16'h1234};
    run_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      run_a = 1'b0;
      ack_a = (c == 2 || c == 5);
      total++; if (hs_a !== exp_hs[c-1])     begin bad++; $display("[TB] FAIL basic_hs c%0d: got %b want %b", c, hs_a, exp_hs[c-1]); end
      total++; if (done_a !== exp_done[c-1]) begin bad++; $display("[TB] FAIL basic_done c%0d: got %b want %b", c, done_a, exp_done[c-1]); end
      total++; if (busy_a !== exp_busy[c-1]) begin bad++; $display("[TB] FAIL basic_busy c%0d: got %b want %b", c, busy_a, exp_busy[c-1]); end
      total++; if (dout_a !== exp_d[c-1])    begin bad++; $display("[TB] FAIL basic_dout c%0d: got %h want %h", c, dout_a, exp_d[c-1]); end
      total++; if (terr_a !== 1'b0)          begin bad++; $display("[TB] FAIL basic_terr c%0d: got %b want 0", c, terr_a); end
    end
    ack_a = 1'b0;
  endtask

  task automatic test_slow_consumer();
    logic got_done, saw_last;
    din_b = {16'h3030, 16'h2020, 16'h1010};
    run_b = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      run_b = 1'b0;
      ack_b = (c == 10);
      total++; if (hs_b !== 1'b1 || dout_b !== 16'h1010) begin bad++; $display("[TB] FAIL slow_hold c%0d: got hs=%b dout=%h want 1 1010", c, hs_b, dout_b); end
    end
    tick();
    ack_b = 1'b0;
    total++; if (hs_b !== 1'b0 || dout_b !== 16'h1010) begin bad++; $display("[TB] FAIL slow_gap: got hs=%b dout=%h want 0 1010", hs_b, dout_b); end
    tick();
    tick();
    tick();
    total++; if (hs_b !== 1'b1 || dout_b !== 16'h2020) begin bad++; $display("[TB] FAIL slow_word1: got hs=%b dout=%h want 1 2020", hs_b, dout_b); end
    ack_b    = 1'b1;
    got_done = 1'b0;
    saw_last = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      tick();
      ack_b = hs_b;
      if (hs_b && dout_b == 16'h3030) saw_last = 1'b1;
      if (done_b) got_done = 1'b1;
    end
    ack_b = 1'b0;
    total++; if (got_done !== 1'b1) begin bad++; $display("[TB] FAIL slow_done: got %b want 1 within 40 cycles", got_done); end
    total++; if (saw_last !== 1'b1) begin bad++; $display("[TB] FAIL slow_word2: got seen=%b want 1", saw_last); end
    tick();
    total++; if (busy_b !== 1'b0) begin bad++; $display("[TB] FAIL slow_idle: got busy=%b want 0", busy_b); end
  endtask

  task automatic test_spurious();
    logic [8:0]  exp_hs, exp_done, exp_busy;
    logic [15:0] exp_d [9];
    exp_hs   = 9'b0_0001_1011;
    exp_done = 9'b0_0100_0000;
    exp_busy = 9'b0_0111_1111;
    exp_d    = '{16'h1111, 16'h1111, 16'h1111, 16'h2222, 16'h2222,
                 16'h2222, 16'h2222, 16'h2222, 16'h2222};
    din_a = {16'h2222, 16'h1111};
    run_a = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) din_a = 32'hDEAD_DEAD;
      run_a = (c == 1 || c == 7);
      ack_a = (c == 2 || c == 3 || c == 5 || c == 7 || c == 8);
      total++; if (hs_a !== exp_hs[c-1])     begin bad++; $display("[TB] FAIL spur_hs c%0d: got %b want %b", c, hs_a, exp_hs[c-1]); end
      total++; if (done_a !== exp_done[c-1]) begin bad++; $display("[TB] FAIL spur_done c%0d: got %b want %b", c, done_a, exp_done[c-1]); end
      total++; if (busy_a !== exp_busy[c-1]) begin bad++; $display("[TB] FAIL spur_busy c%0d: got %b want %b", c, busy_a, exp_busy[c-1]); end
      total++; if (dout_a !== exp_d[c-1])    begin bad++; $display("[TB] FAIL spur_dout c%0d: got %h want %h", c, dout_a, exp_d[c-1]); end
    end
    run_a = 1'b0;
    ack_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_hs, exp_done, exp_busy;
    logic [15:0] exp_d [16];
    exp_hs   = 16'b0001_1011_0001_1011;
    exp_done = 16'b0100_0000_0100_0000;
    exp_busy = 16'b0111_1111_0111_1111;
    exp_d    = '{16'h8888, 16'h8888, 16'h8888, 16'h9999, 16'h9999, 16'h9999,
                 16'h9999, 16'h9999, 16'h2020, 16'h2020, 16'h2020, 16'h1010,
                 16'h1010, 16'h1010, 16'h1010, 16'h1010};
    din_a = {16'h9999, 16'h8888};
    run_a = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 3) din_a = {16'h1010, 16'h2020};
      if (c == 16) run_a = 1'b0;
      ack_a = (c == 2 || c == 5 || c == 10 || c == 13);
      total++; if (hs_a !== exp_hs[c-1])     begin bad++; $display("[TB] FAIL b2b_hs c%0d: got %b want %b", c, hs_a, exp_hs[c-1]); end
      total++; if (done_a !== exp_done[c-1]) begin bad++; $display("[TB] FAIL b2b_done c%0d: got %b want %b", c, done_a, exp_done[c-1]); end
      total++; if (busy_a !== exp_busy[c-1]) begin bad++; $display("[TB] FAIL b2b_busy c%0d: got %b want %b", c, busy_a, exp_busy[c-1]); end
      total++; if (dout_a !== exp_d[c-1])    begin bad++; $display("[TB] FAIL b2b_dout c%0d: got %h want %h", c, dout_a, exp_d[c-1]); end
    end
    ack_a = 1'b0;
    tick();
    total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stop: got busy=%b want 0", busy_a); end
  endtask

  task automatic test_reset_mid();
    logic got_done, saw_w1;
    din_a = {16'h4444, 16'h3333};
    run_a = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      run_a = 1'b0;
      ack_a = (c == 2);
    end
    total++; if (hs_a !== 1'b1 || dout_a !== 16'h4444) begin bad++; $display("[TB] FAIL rmid_pre: got hs=%b dout=%h want 1 4444", hs_a, dout_a); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (hs_a !== 1'b0)    begin bad++; $display("[TB] FAIL rmid_hs: got %b want 0", hs_a); end
    total++; if (dout_a !== 16'h0) begin bad++; $display("[TB] FAIL rmid_dout: got %h want 0000", dout_a); end
    total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy: got busy=%b done=%b want 0 0", busy_a, done_a); end
    din_a = {16'h6666, 16'h7777};
    run_a = 1'b1;
    tick();
    run_a = 1'b0;
    total++; if (hs_a !== 1'b1 || dout_a !== 16'h7777) begin bad++; $display("[TB] FAIL rmid_restart: got hs=%b dout=%h want 1 7777", hs_a, dout_a); end
    ack_a    = 1'b1;
    got_done = 1'b0;
    saw_w1   = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      tick();
      ack_a = hs_a;
      if (hs_a && dout_a == 16'h6666) saw_w1 = 1'b1;
      if (done_a) got_done = 1'b1;
    end
    ack_a = 1'b0;
    total++; if (got_done !== 1'b1 || saw_w1 !== 1'b1) begin bad++; $display("[TB] FAIL rmid_finish: got done=%b word1=%b want 1 1", got_done, saw_w1); end
    tick();
  endtask

  task automatic test_gap_length();
    logic [13:0] exp_hs, exp_done, exp_busy;
    logic [15:0] exp_d [14];
    exp_hs   = 14'b00_0001_0001_0001;
    exp_done = 14'b01_0000_0000_0000;
    exp_busy = 14'b01_1111_1111_1111;
    exp_d    = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hBBBB, 16'hBBBB,
                 16'hBBBB, 16'hCCCC, 16'hCCCC, 16'hCCCC, 16'hCCCC, 16'hCCCC, 16'hCCCC};
    din_b = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    run_b = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      run_b = 1'b0;
      ack_b = (c == 1 || c == 3 || c == 5 || c == 9);
      total++; if (hs_b !== exp_hs[c-1])     begin bad++; $display("[TB] FAIL gap_hs c%0d: got %b want %b", c, hs_b, exp_hs[c-1]); end
      total++; if (done_b !== exp_done[c-1]) begin bad++; $display("[TB] FAIL gap_done c%0d: got %b want %b", c, done_b, exp_done[c-1]); end
      total++; if (busy_b !== exp_busy[c-1]) begin bad++; $display("[TB] FAIL gap_busy c%0d: got %b want %b", c, busy_b, exp_busy[c-1]); end
      total++; if (dout_b !== exp_d[c-1])    begin bad++; $display("[TB] FAIL gap_dout c%0d: got %h want %h", c, dout_b, exp_d[c-1]); end
    end
    ack_b = 1'b0;
  endtask

  task automatic test_single_word();
    logic [4:0] exp_hs, exp_done, exp_busy;
    exp_hs   = 5'b00011;
    exp_done = 5'b01000;
    exp_busy = 5'b01111;
    din_c = 16'hD00D;
    run_c = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      run_c = 1'b0;
      ack_c = (c == 2);
      total++; if (hs_c !== exp_hs[c-1])     begin bad++; $display("[TB] FAIL one_hs c%0d: got %b want %b", c, hs_c, exp_hs[c-1]); end
      total++; if (done_c !== exp_done[c-1]) begin bad++; $display("[TB] FAIL one_done c%0d: got %b want %b", c, done_c, exp_done[c-1]); end
      total++; if (busy_c !== exp_busy[c-1]) begin bad++; $display("[TB] FAIL one_busy c%0d: got %b want %b", c, busy_c, exp_busy[c-1]); end
      total++; if (dout_c !== 16'hD00D)      begin bad++; $display("[TB] FAIL one_dout c%0d: got %h want d00d", c, dout_c); end
    end
    ack_c = 1'b0;
  endtask

`ifdef WRITE_SM_TIMEOUT_EN
  task automatic test_timeout();
    logic got_done;
    din_a = {16'h5A5A, 16'hA5A5};
    run_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      run_a = 1'b0;
      total++; if (hs_a !== 1'b1 || terr_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("[TB] FAIL tmo_wait c%0d: got hs=%b terr=%b done=%b want 1 0 0", c, hs_a, terr_a, done_a); end
    end
    tick();
    total++; if (hs_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("[TB] FAIL tmo_abort: got hs=%b busy=%b want 0 0", hs_a, busy_a); end
    total++; if (terr_a !== 1'b1 || done_a !== 1'b0) begin bad++; $display("[TB] FAIL tmo_flag: got terr=%b done=%b want 1 0", terr_a, done_a); end
    din_a = {16'h0F0F, 16'hF0F0};
    run_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      run_a = 1'b0;
      ack_a = (c == 8);
      total++; if (hs_a !== 1'b1 || terr_a !== 1'b0 || dout_a !== 16'hF0F0) begin bad++; $display("[TB] FAIL tmo_rerun c%0d: got hs=%b terr=%b dout=%h want 1 0 f0f0", c, hs_a, terr_a, dout_a); end
    end
    tick();
    ack_a = 1'b0;
    total++; if (hs_a !== 1'b0 || busy_a !== 1'b1 || terr_a !== 1'b0) begin bad++; $display("[TB] FAIL tmo_ackwins: got hs=%b busy=%b terr=%b want 0 1 0", hs_a, busy_a, terr_a); end
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      tick();
      ack_a = hs_a;
      if (done_a) got_done = 1'b1;
    end
    ack_a = 1'b0;
    total++; if (got_done !== 1'b1) begin bad++; $display("[TB] FAIL tmo_finish: got done=%b want 1", got_done); end
    tick();
  endtask
`endif

  initial begin
    $display("[TB] write_sm directed checks starting");
    test_reset();
    test_basic();
    test_slow_consumer();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    test_gap_length();
    test_single_word();
`ifdef WRITE_SM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
